// File: rtl/wb_sram_bridge_pkg.sv
// Shared types and elaboration-time helpers for the Wishbone-to-SRAM byte-enable bridge.
// Holds the FSM state encoding and the address-split constants.
package wb_sram_bridge_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_ACK,
      S_ERR
   } state_t;

   // Number of byte-address bits that select a byte lane within one data word.
   function automatic int offset_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   // Ones over bits [wb_aw-1:lo]: the address bits that must match the window base.
   function automatic logic [63:0] window_mask(input int wb_aw, input int lo);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++) begin
         if (i >= lo && i < wb_aw) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_sram_byte_en_bridge.sv
// Wishbone classic slave that maps a fixed address window onto a byte-enable SRAM
// with registered read data; out-of-window requests are answered with a one-cycle err.
module wb_sram_byte_en_bridge
   import wb_sram_bridge_pkg::*;
#(
   parameter int                       ADDRESS_WIDTH = 7,
   parameter int                       DATA_WIDTH    = 32,
   parameter int                       WB_ADDR_WIDTH = 32,
   parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = 32'h1000_0000
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [WB_ADDR_WIDTH-1:0] i_wb_adr,
   input  logic [DATA_WIDTH-1:0]    i_wb_dat,
   input  logic [DATA_WIDTH/8-1:0]  i_wb_sel,
   input  logic                     i_wb_we,
   input  logic                     i_wb_cyc,
   input  logic                     i_wb_stb,
   output logic [DATA_WIDTH-1:0]    o_wb_dat,
   output logic                     o_wb_ack,
   output logic                     o_wb_err,
   output logic [ADDRESS_WIDTH-1:0] o_sram_address,
   output logic [DATA_WIDTH-1:0]    o_sram_write_data,
   output logic                     o_sram_write_enable,
   output logic [DATA_WIDTH/8-1:0]  o_sram_byte_enable,
   input  logic [DATA_WIDTH-1:0]    i_sram_read_data
);

   localparam int OFFSET = offset_bits(DATA_WIDTH);
   localparam logic [WB_ADDR_WIDTH-1:0] WIN_MASK =
      WB_ADDR_WIDTH'(window_mask(WB_ADDR_WIDTH, ADDRESS_WIDTH + OFFSET));

   state_t state;
   logic   wr_q;
   logic   req;
   logic   in_window;
   logic [ADDRESS_WIDTH-1:0] word_addr;

   always_comb begin
      req       = i_wb_cyc & i_wb_stb;
      in_window = ((i_wb_adr ^ BASE_ADDR) & WIN_MASK) == '0;
      word_addr = i_wb_adr[ADDRESS_WIDTH+OFFSET-1:OFFSET];
   end

   // NOTE: all state and outputs use non-blocking assignments so every register
   // samples pre-edge values; blocking here would create ordering-dependent logic.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state               <= S_IDLE;
         wr_q                <= 1'b0;
         o_wb_dat            <= '0;
         o_wb_ack            <= 1'b0;
         o_wb_err            <= 1'b0;
         o_sram_address      <= '0;
         o_sram_write_data   <= '0;
         o_sram_write_enable <= 1'b0;
         o_sram_byte_enable  <= '0;
      end else begin
         // Handshake flags are single-cycle pulses; only ISSUE/CAPTURE/IDLE raise them.
         o_wb_ack <= 1'b0;
         o_wb_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (in_window) begin
                     o_sram_address      <= word_addr;
                     o_sram_write_data   <= i_wb_dat;
                     o_sram_byte_enable  <= i_wb_we ? i_wb_sel : '0;
                     o_sram_write_enable <= i_wb_we && (i_wb_sel != '0);
                     wr_q                <= i_wb_we;
                     state               <= S_ISSUE;
                  end else begin
                     o_wb_err <= 1'b1;
                     state    <= S_ERR;
                  end
               end
            end
            S_ISSUE: begin
               o_sram_write_enable <= 1'b0;
               if (!i_wb_cyc) begin
                  state <= S_IDLE;
               end else if (wr_q) begin
                  o_wb_ack <= 1'b1;
                  state    <= S_ACK;
               end else begin
                  state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               // The SRAM read data is valid here, one clock after the address was presented.
               if (!i_wb_cyc) begin
                  state <= S_IDLE;
               end else begin
                  o_wb_dat <= i_sram_read_data;
                  o_wb_ack <= 1'b1;
                  state    <= S_ACK;
               end
            end
            S_ACK, S_ERR: state <= S_IDLE;
            default:      state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_sram_byte_en_bridge.sv
// Self-checking bench: directed scenarios plus randomized transfers against a
// word-array reference model, with a byte-enable SRAM model attached to the bridge.
module tb_wb_sram_byte_en_bridge;

   localparam int          AW   = 7;
   localparam int          DW   = 32;
   localparam int          WAW  = 32;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          WIN_BYTES = (1 << AW) * (DW / 8);

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [31:0]   i_wb_adr;
   logic [31:0]   i_wb_dat;
   logic [3:0]    i_wb_sel;
   logic          i_wb_we;
   logic          i_wb_cyc;
   logic          i_wb_stb;
   logic [31:0]   o_wb_dat;
   logic          o_wb_ack;
   logic          o_wb_err;
   logic [AW-1:0] o_sram_address;
   logic [31:0]   o_sram_write_data;
   logic          o_sram_write_enable;
   logic [3:0]    o_sram_byte_enable;
   logic [31:0]   i_sram_read_data;

   wb_sram_byte_en_bridge #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .WB_ADDR_WIDTH(WAW),
      .BASE_ADDR    (BASE)
   ) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_wb_adr           (i_wb_adr),
      .i_wb_dat           (i_wb_dat),
      .i_wb_sel           (i_wb_sel),
      .i_wb_we            (i_wb_we),
      .i_wb_cyc           (i_wb_cyc),
      .i_wb_stb           (i_wb_stb),
      .o_wb_dat           (o_wb_dat),
      .o_wb_ack           (o_wb_ack),
      .o_wb_err           (o_wb_err),
      .o_sram_address     (o_sram_address),
      .o_sram_write_data  (o_sram_write_data),
      .o_sram_write_enable(o_sram_write_enable),
      .o_sram_byte_enable (o_sram_byte_enable),
      .i_sram_read_data   (i_sram_read_data)
   );

   always #5 i_clk = ~i_clk;

   // Byte-enable SRAM with registered read port.
   logic [31:0] sram    [1 << AW];
   logic [31:0] ref_mem [1 << AW];

   always @(posedge i_clk) begin
      if (o_sram_write_enable) begin
         for (int b = 0; b < 4; b++) begin
            if (o_sram_byte_enable[b]) sram[o_sram_address][8*b +: 8] = o_sram_write_data[8*b +: 8];
         end
      end
      i_sram_read_data <= sram[o_sram_address];
   end

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   int          we_cnt   = 0;
   int          ack_cnt  = 0;
   int          err_cnt  = 0;
   int          both_cnt = 0;
   logic [AW-1:0] we_addr;

   always @(negedge i_clk) begin
      if (o_sram_write_enable) begin
         we_cnt  = we_cnt + 1;
         we_addr = o_sram_address;
      end
      if (o_wb_ack) ack_cnt = ack_cnt + 1;
      if (o_wb_err) err_cnt = err_cnt + 1;
      if (o_wb_ack && o_wb_err) both_cnt = both_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic idle_bus();
      i_wb_cyc = 1'b0;
      i_wb_stb = 1'b0;
      i_wb_we  = 1'b0;
   endtask

   // One complete Wishbone transfer, checked against the reference model.
   task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
      logic [31:0] prev_dat;
      bit          in_win;
      int          word;
      int          n;
      in_win   = (adr >= BASE) && (adr < BASE + WIN_BYTES);
      word     = in_win ? int'((adr - BASE) / 4) : 0;
      prev_dat = o_wb_dat;
      we_cnt   = 0;
      i_wb_adr = adr;
      i_wb_dat = dat;
      i_wb_sel = sel;
      i_wb_we  = we;
      i_wb_cyc = 1'b1;
      i_wb_stb = 1'b1;
      @(posedge i_clk); #1;
      if (!in_win) begin
         check({tag, " err"}, o_wb_err, 1);
         check({tag, " no_ack"}, o_wb_ack, 0);
         idle_bus();
         @(posedge i_clk); #1;
         check({tag, " err_one_cycle"}, o_wb_err, 0);
         check({tag, " dat_kept"}, o_wb_dat, prev_dat);
      end else begin
         check({tag, " sram_addr"}, o_sram_address, word);
         if (!we) check({tag, " be_read_zero"}, o_sram_byte_enable, 0);
         n = 0;
         while (!o_wb_ack && n < 8) begin
            @(posedge i_clk); #1;
            n++;
         end
         check({tag, " ack_latency"}, n, we ? 1 : 2);
         check({tag, " no_err"}, o_wb_err, 0);
         check({tag, " rdata"}, o_wb_dat, we ? prev_dat : ref_mem[word]);
         idle_bus();
         @(posedge i_clk); #1;
         check({tag, " ack_one_cycle"}, o_wb_ack, 0);
         if (we) ref_mem[word] = merge(ref_mem[word], dat, sel);
      end
      check({tag, " we_pulses"}, we_cnt, (in_win && we && sel != 0) ? 1 : 0);
      if (in_win && we && sel != 0) check({tag, " we_addr"}, we_addr, word);
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] prev;
      for (int i = 0; i < (1 << AW); i++) begin
         v          = $urandom;
         sram[i]    = v;
         ref_mem[i] = v;
      end
      i_rst_n  = 1'b0;
      i_wb_adr = '0;
      i_wb_dat = '0;
      i_wb_sel = '0;
      idle_bus();
      repeat (3) @(posedge i_clk);
      #1;
      check("reset ack", o_wb_ack, 0);
      check("reset err", o_wb_err, 0);
      check("reset we", o_sram_write_enable, 0);
      check("reset dat", o_wb_dat, 0);
      check("reset addr", o_sram_address, 0);
      check("reset be", o_sram_byte_enable, 0);
      check("reset wdata", o_sram_write_data, 0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      xfer("wr_full", 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1);
      xfer("wr_byte0", 32'h1000_0010, 32'h0000_00AA, 4'b0001, 1'b1);
      xfer("rd_merged", 32'h1000_0010, 32'h0, 4'b0000, 1'b0);
      check("merged_value", o_wb_dat, 32'hDEAD_BEAA);

      ack_cnt = 0;
      xfer("rd_oow", 32'h2000_0000, 32'h0, 4'b1111, 1'b0);
      check("oow_no_ack", ack_cnt, 0);

      xfer("wr_sel0", 32'h1000_0020, 32'h1234_5678, 4'b0000, 1'b1);
      xfer("rd_sel0", 32'h1000_0020, 32'h0, 4'b0000, 1'b0);
      xfer("wr_top", BASE + WIN_BYTES - 4, 32'hCAFE_F00D, 4'b1010, 1'b1);
      xfer("rd_top", BASE + WIN_BYTES - 1, 32'h0, 4'b0000, 1'b0);
      xfer("wr_below", BASE - 4, 32'h5555_5555, 4'b1111, 1'b1);
      xfer("rd_above", BASE + WIN_BYTES, 32'h0, 4'b0000, 1'b0);

      // Abort a read while it waits in CAPTURE.
      prev     = o_wb_dat;
      ack_cnt  = 0;
      err_cnt  = 0;
      i_wb_adr = 32'h1000_0008;
      i_wb_we  = 1'b0;
      i_wb_sel = 4'b0000;
      i_wb_cyc = 1'b1;
      i_wb_stb = 1'b1;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      idle_bus();
      repeat (3) @(posedge i_clk);
      #1;
      check("abort no_ack", ack_cnt, 0);
      check("abort no_err", err_cnt, 0);
      check("abort dat_kept", o_wb_dat, prev);
      xfer("wr_after_abort", 32'h1000_0008, 32'h0BAD_F00D, 4'b1100, 1'b1);

      // Reset pulse while a write sits in ISSUE: the write must not reach the SRAM.
      ack_cnt  = 0;
      i_wb_adr = 32'h1000_0014;
      i_wb_dat = 32'hFFFF_FFFF;
      i_wb_sel = 4'b1111;
      i_wb_we  = 1'b1;
      i_wb_cyc = 1'b1;
      i_wb_stb = 1'b1;
      @(posedge i_clk); #1;
      check("rst_mid we_before", o_sram_write_enable, 1);
      #1 i_rst_n = 1'b0;
      #1;
      check("rst_mid we", o_sram_write_enable, 0);
      check("rst_mid ack", o_wb_ack, 0);
      check("rst_mid err", o_wb_err, 0);
      check("rst_mid addr", o_sram_address, 0);
      check("rst_mid be", o_sram_byte_enable, 0);
      check("rst_mid wdata", o_sram_write_data, 0);
      check("rst_mid dat", o_wb_dat, 0);
      idle_bus();
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      check("rst_mid no_ack", ack_cnt, 0);
      xfer("rd_after_rst", 32'h1000_0014, 32'h0, 4'b0000, 1'b0);

      for (int i = 0; i < 24; i++) begin
         logic [31:0] adr;
         if ($urandom_range(0, 5) == 0) adr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
         else adr = BASE + $urandom_range(0, WIN_BYTES - 1);
         xfer($sformatf("rnd%0d", i), adr, $urandom, 4'($urandom), 1'($urandom));
      end

      for (int i = 0; i < 8; i++) begin
         xfer($sformatf("rdback%0d", i), BASE + 4 * $urandom_range(0, (1 << AW) - 1),
              32'h0, 4'b0000, 1'b0);
      end

      check("ack_err_exclusive", both_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_sram_byte_en_bridge.md
WB_SRAM_BYTE_EN_BRIDGE -- requirements
Module: wb_sram_byte_en_bridge

Interface
REQ-001 The block SHALL have the parameter ADDRESS_WIDTH, default 7, which is the SRAM word-address width.
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 32, which is the data width; it is a multiple of 8.
REQ-003 The block SHALL have the parameter WB_ADDR_WIDTH, default 32, which is the Wishbone byte-address width.
REQ-004 The block SHALL have the parameter BASE_ADDR, default 32'h1000_0000, which is the byte base address of the SRAM window.
REQ-005 The block SHALL have one clock and one reset: reset is asynchronous, active-low.
REQ-006 The block SHALL have these ports:
- i_clk, input, 1 bit: clock.
- i_rst_n, input, 1 bit: asynchronous active-low reset.
- i_wb_adr, input, WB_ADDR_WIDTH bits: byte address.
- i_wb_dat, input, DATA_WIDTH bits: write data.
- i_wb_sel, input, DATA_WIDTH/8 bits: byte selects.
- i_wb_we, input, 1 bit: write request.
- i_wb_cyc, input, 1 bit: bus cycle active.
- i_wb_stb, input, 1 bit: strobe.
- o_wb_dat, output, DATA_WIDTH bits: read data.
- o_wb_ack, output, 1 bit: transfer acknowledge.
- o_wb_err, output, 1 bit: out-of-window error.
- o_sram_address, output, ADDRESS_WIDTH bits: SRAM word address.
- o_sram_write_data, output, DATA_WIDTH bits: SRAM write data.
- o_sram_write_enable, output, 1 bit: SRAM write strobe.
- o_sram_byte_enable, output, DATA_WIDTH/8 bits: SRAM byte enables.
- i_sram_read_data, input, DATA_WIDTH bits: SRAM registered read data, valid one clock after the address edge.

Function
REQ-007 OFFSET SHALL equal clog2(DATA_WIDTH/8), and the word address SHALL be i_wb_adr[ADDRESS_WIDTH+OFFSET-1:OFFSET].
REQ-008 A request SHALL be in-window when i_wb_adr[WB_ADDR_WIDTH-1:ADDRESS_WIDTH+OFFSET] equals the same bits of BASE_ADDR, and out-of-window otherwise.
REQ-009 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, ACK and ERR, and all outputs SHALL be registered.
REQ-010 In IDLE, when i_wb_cyc&i_wb_stb is high and the request is in-window, the block SHALL register the SRAM address, write data and byte enables and go to ISSUE.
- For a write with i_wb_sel!=0, o_sram_write_enable SHALL be set to 1.
- For a write with i_wb_sel==0, no SRAM write SHALL occur, but the transfer SHALL still be acked.
REQ-011 In IDLE, when i_wb_cyc&i_wb_stb is high and the request is out-of-window, the block SHALL go to ERR, make no SRAM access, and hold o_sram_write_enable at 0.
REQ-012 In ISSUE, o_sram_write_enable SHALL be cleared; a write SHALL then go to ACK and a read SHALL go to CAPTURE.
REQ-013 In CAPTURE, the block SHALL register i_sram_read_data into o_wb_dat and go to ACK.
REQ-014 In ACK, o_wb_ack SHALL be 1 for exactly one cycle, followed by IDLE; in ERR, o_wb_err SHALL be 1 for exactly one cycle, followed by IDLE.
REQ-015 Latency, counted from the request-sampling edge: write ack visible after 2 edges; read ack visible after 3 edges; err visible after 1 edge.
REQ-016 o_wb_dat SHALL hold its last read value until the next CAPTURE, and SHALL not be altered by writes.
REQ-017 A strobe sampled in ACK or ERR SHALL be ignored; the next request SHALL be accepted only from IDLE, giving at most one outstanding transfer.
REQ-018 If i_wb_cyc is low in ISSUE or CAPTURE, the transfer SHALL be aborted and the FSM SHALL return to IDLE with no ack or err. An SRAM write already strobed SHALL stand.
REQ-019 o_wb_ack and o_wb_err SHALL never be high in the same cycle.
REQ-020 The block SHALL not drive o_sram_byte_enable on reads; it SHALL be 0 on reads.

Reset
REQ-021 On i_rst_n low, the FSM SHALL go to IDLE immediately (asynchronously), and all outputs SHALL be cleared to 0, including o_sram_write_enable and o_wb_ack.
REQ-022 A reset asserted mid-transfer SHALL drop the transfer with no ack, and the first request after release SHALL be handled normally.

Structure
REQ-023 A shared package wb_sram_bridge_pkg SHALL hold the state enum and the OFFSET/window-mask constant functions.
REQ-024 The block SHALL have no sub-module; it SHALL consist of one FSM plus output registers and be directly connectable to the byte-enable SRAM BFM.

Verification
Each scenario below uses DATA_WIDTH=32, ADDRESS_WIDTH=7 and BASE_ADDR=0x1000_0000.
REQ-025 Write 0x1000_0010, dat 0xDEADBEEF, sel 4'b1111: o_sram_address 4 with write_enable for exactly one cycle; ack 2 edges after the request.
REQ-026 Write 0x1000_0010, dat 0x000000AA, sel 4'b0001, then a read of 0x1000_0010: o_wb_dat 0xDEADBEAA; ack 3 edges after the request.
REQ-027 Read 0x2000_0000: o_wb_err for one cycle; no ack; o_sram_write_enable never high.
REQ-028 Write with sel 4'b0000: ack after 2 edges; SRAM contents unchanged; write_enable stays 0.
REQ-029 Read issued and i_wb_cyc dropped in CAPTURE: no ack; FSM in IDLE; next write completes normally.
REQ-030 i_rst_n pulsed low during ISSUE of a write: all outputs 0 within the same cycle; no ack; a subsequent read returns correct data.
